// File: rtl/register_file.sv
// register_file: renaming register file with ROB tags, commit bypass and rollback
module register_file #(
    parameter int REG_COUNT  = 32,
    parameter int WORD_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rollback_in,
    input  logic [4:0]            dec_rs1_in,
    input  logic [4:0]            dec_rs2_in,
    output logic [WORD_WIDTH-1:0] dec_Vj_out,
    output logic [WORD_WIDTH-1:0] dec_Vk_out,
    output logic [TAG_WIDTH-1:0]  dec_Qj_out,
    output logic [TAG_WIDTH-1:0]  dec_Qk_out,
    input  logic                  dec_issue_in,
    input  logic [4:0]            dec_rd_in,
    input  logic [TAG_WIDTH-1:0]  dec_tag_in,
    input  logic                  commit_rf_signal_in,
    input  logic [TAG_WIDTH-1:0]  commit_tag_in,
    input  logic [WORD_WIDTH-1:0] commit_data_in,
    input  logic [4:0]            commit_target_in
);
    logic [WORD_WIDTH-1:0] value_q [REG_COUNT];
    logic [WORD_WIDTH-1:0] value_d [REG_COUNT];
    logic [TAG_WIDTH-1:0]  tag_q   [REG_COUNT];
    logic [TAG_WIDTH-1:0]  tag_d   [REG_COUNT];
    logic                  commit_ok;
    logic                  bypass_j;
    logic                  bypass_k;

    assign commit_ok = commit_rf_signal_in && (commit_target_in != 5'd0);

    // Next state: commit writes value and retires a matching tag; rollback wipes tags, else issue renames (issue beats clear)
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (commit_ok) begin
            value_d[commit_target_in] = commit_data_in;
            if (tag_q[commit_target_in] == commit_tag_in) tag_d[commit_target_in] = '0;
        end
        if (rollback_in) tag_d = '{default: '0};
        else if (dec_issue_in && (dec_rd_in != 5'd0)) tag_d[dec_rd_in] = dec_tag_in;
    end

    // Read ports see pre-issue state, with the committing result forwarded when it retires the current producer
    always_comb begin
        bypass_j   = commit_ok && (commit_target_in == dec_rs1_in) && (tag_q[dec_rs1_in] == commit_tag_in);
        bypass_k   = commit_ok && (commit_target_in == dec_rs2_in) && (tag_q[dec_rs2_in] == commit_tag_in);
        dec_Vj_out = bypass_j ? commit_data_in : value_q[dec_rs1_in];
        dec_Qj_out = bypass_j ? '0 : tag_q[dec_rs1_in];
        dec_Vk_out = bypass_k ? commit_data_in : value_q[dec_rs2_in];
        dec_Qk_out = bypass_k ? '0 : tag_q[dec_rs2_in];
    end

    // State registers; x0 is never written so it stays zero from reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end
endmodule
